// File: rtl/riscv_rf_writeback_if.sv
// Writeback bus bundle: EX result, LSU load stream, two RF write ports,
// queue occupancy and the forwarding lookup.
interface riscv_rf_writeback_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  ex_valid_i;
  logic [ADDR_WIDTH-1:0] ex_waddr_i;
  logic [DATA_WIDTH-1:0] ex_wdata_i;
  logic                  lsu_valid_i;
  logic [ADDR_WIDTH-1:0] lsu_waddr_i;
  logic [DATA_WIDTH-1:0] lsu_wdata_i;
  logic                  lsu_ready_o;
  logic [ADDR_WIDTH-1:0] waddr_a_o;
  logic [DATA_WIDTH-1:0] wdata_a_o;
  logic                  we_a_o;
  logic [ADDR_WIDTH-1:0] waddr_b_o;
  logic [DATA_WIDTH-1:0] wdata_b_o;
  logic                  we_b_o;
  logic [CW-1:0]         count_o;
  logic [ADDR_WIDTH-1:0] fwd_raddr_i;
  logic                  fwd_hit_o;
  logic [DATA_WIDTH-1:0] fwd_data_o;

  // Pipeline side: produces results, observes the register file writes.
  modport master (
    output ex_valid_i, ex_waddr_i, ex_wdata_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i, fwd_raddr_i,
    input  lsu_ready_o, waddr_a_o, wdata_a_o, we_a_o,
    input  waddr_b_o, wdata_b_o, we_b_o, count_o, fwd_hit_o, fwd_data_o
  );

  // Writeback block side.
  modport slave (
    input  ex_valid_i, ex_waddr_i, ex_wdata_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i, fwd_raddr_i,
    output lsu_ready_o, waddr_a_o, wdata_a_o, we_a_o,
    output waddr_b_o, wdata_b_o, we_b_o, count_o, fwd_hit_o, fwd_data_o
  );
endinterface

// File: rtl/riscv_rf_writeback.sv
// Register file writeback: EX results on port A, queued LSU loads on port B.
// Optional forwarding lookup is enabled with the RF_WB_FWD_EN macro.
module riscv_rf_writeback #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_rf_writeback_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] fifo_addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  we_a_q, we_a_d, we_b_q, we_b_d;
  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;

  logic                  ready, push, pop, ex_wr, b_wr;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  always_comb begin
    ready     = (count_q != CW'(DEPTH));
    push      = bus.lsu_valid_i & ready;
    pop       = (count_q != '0);
    head_addr = fifo_addr_q[rd_ptr_q];
    head_data = fifo_data_q[rd_ptr_q];
    ex_wr     = bus.ex_valid_i & (bus.ex_waddr_i != '0);
    // A same-cycle EX write to the popped address is younger; the load is dropped.
    b_wr      = pop & (head_addr != '0) &
                ~(bus.ex_valid_i & (bus.ex_waddr_i == head_addr));

    we_a_d    = ex_wr;
    waddr_a_d = waddr_a_q;
    wdata_a_d = wdata_a_q;
    if (ex_wr) begin
      waddr_a_d = bus.ex_waddr_i;
      wdata_a_d = bus.ex_wdata_i;
    end

    we_b_d    = b_wr;
    waddr_b_d = waddr_b_q;
    wdata_b_d = wdata_b_q;
    if (b_wr) begin
      waddr_b_d = head_addr;
      wdata_b_d = head_data;
    end

    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = bus.lsu_waddr_i;
      fifo_data_d[wr_ptr_q] = bus.lsu_wdata_i;
    end

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_a_q    <= 1'b0;
      we_b_q    <= 1'b0;
      waddr_a_q <= '0;
      wdata_a_q <= '0;
      waddr_b_q <= '0;
      wdata_b_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      we_a_q    <= we_a_d;
      we_b_q    <= we_b_d;
      waddr_a_q <= waddr_a_d;
      wdata_a_q <= wdata_a_d;
      waddr_b_q <= waddr_b_d;
      wdata_b_q <= wdata_b_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Queue storage carries no reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

  assign bus.lsu_ready_o = ready;
  assign bus.we_a_o      = we_a_q;
  assign bus.waddr_a_o   = waddr_a_q;
  assign bus.wdata_a_o   = wdata_a_q;
  assign bus.we_b_o      = we_b_q;
  assign bus.waddr_b_o   = waddr_b_q;
  assign bus.wdata_b_o   = wdata_b_q;
  assign bus.count_o     = count_q;

`ifdef RF_WB_FWD_EN
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [PW-1:0]         idx;

  // Scan oldest to youngest so later matches override; port B then port A win last.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (bus.fwd_raddr_i != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + PW'(i);
        if ((CW'(i) < count_q) && (fifo_addr_q[idx] == bus.fwd_raddr_i)) begin
          fwd_hit  = 1'b1;
          fwd_data = fifo_data_q[idx];
        end
      end
      if (we_b_q && (waddr_b_q == bus.fwd_raddr_i)) begin
        fwd_hit  = 1'b1;
        fwd_data = wdata_b_q;
      end
      if (we_a_q && (waddr_a_q == bus.fwd_raddr_i)) begin
        fwd_hit  = 1'b1;
        fwd_data = wdata_a_q;
      end
    end
  end

  assign bus.fwd_hit_o  = fwd_hit;
  assign bus.fwd_data_o = fwd_data;
`else
  logic unused_fwd_raddr;
  assign unused_fwd_raddr = ^bus.fwd_raddr_i;
  assign bus.fwd_hit_o    = 1'b0;
  assign bus.fwd_data_o   = '0;
`endif

endmodule

// File: tb/tb_riscv_rf_writeback.sv
// Randomised bench for riscv_rf_writeback with a queue-based reference model
// and directed literal scenarios.
module tb_riscv_rf_writeback;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_rf_writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  riscv_rf_writeback #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending loads as a queue, write ports as plain variables.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;
  ent_t          mq[$];
  bit            mvalid = 0;
  logic          m_we_a, m_we_b;
  logic [AW-1:0] m_waddr_a, m_waddr_b;
  logic [DW-1:0] m_wdata_a, m_wdata_b;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_we_a = 0; m_we_b = 0;
      m_waddr_a = '0; m_wdata_a = '0;
      m_waddr_b = '0; m_wdata_b = '0;
      mvalid = 1;
    end else if (mvalid) begin
      bit   can_push;
      ent_t h;
      can_push = (mq.size() != DEPTH);
      m_we_a = 0;
      if (bus.ex_valid_i && bus.ex_waddr_i != 0) begin
        m_we_a = 1; m_waddr_a = bus.ex_waddr_i; m_wdata_a = bus.ex_wdata_i;
      end
      m_we_b = 0;
      if (mq.size() > 0) begin
        h = mq.pop_front();
        if (h.a != 0 && !(bus.ex_valid_i && bus.ex_waddr_i == h.a)) begin
          m_we_b = 1; m_waddr_b = h.a; m_wdata_b = h.d;
        end
      end
      if (bus.lsu_valid_i && can_push) begin
        h.a = bus.lsu_waddr_i; h.d = bus.lsu_wdata_i;
        mq.push_back(h);
      end
    end
  end

  task automatic model_fwd(output logic hit, output logic [DW-1:0] data);
    hit = 0; data = '0;
`ifdef RF_WB_FWD_EN
    if (bus.fwd_raddr_i != 0) begin
      if (m_we_a && m_waddr_a == bus.fwd_raddr_i) begin
        hit = 1; data = m_wdata_a;
      end else if (m_we_b && m_waddr_b == bus.fwd_raddr_i) begin
        hit = 1; data = m_wdata_b;
      end else begin
        for (int i = mq.size() - 1; i >= 0; i--) begin
          if (!hit && mq[i].a == bus.fwd_raddr_i) begin
            hit = 1; data = mq[i].d;
          end
        end
      end
    end
`endif
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      logic          e_hit;
      logic [DW-1:0] e_data;
      model_fwd(e_hit, e_data);
      chk("we_a", bus.we_a_o, m_we_a);
      chk("waddr_a", bus.waddr_a_o, m_waddr_a);
      chk("wdata_a", bus.wdata_a_o, m_wdata_a);
      chk("we_b", bus.we_b_o, m_we_b);
      chk("waddr_b", bus.waddr_b_o, m_waddr_b);
      chk("wdata_b", bus.wdata_b_o, m_wdata_b);
      chk("count", bus.count_o, mq.size());
      chk("lsu_ready", bus.lsu_ready_o, mq.size() != DEPTH);
      chk("fwd_hit", bus.fwd_hit_o, e_hit);
      if (e_hit) chk("fwd_data", bus.fwd_data_o, e_data);
`ifndef RF_WB_FWD_EN
      chk("fwd_data_tied", bus.fwd_data_o, 0);
`endif
    end
  end

  // Advance one cycle; inputs change 2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.ex_valid_i = 0; bus.lsu_valid_i = 0;
  endtask

  task automatic ex(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ex_valid_i = 1; bus.ex_waddr_i = a; bus.ex_wdata_i = d;
  endtask

  task automatic ld(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.lsu_valid_i = 1; bus.lsu_waddr_i = a; bus.lsu_wdata_i = d;
  endtask

  initial begin
    logic [AW-1:0] got[$];
    int            first_k;

    bus.ex_valid_i = 0; bus.ex_waddr_i = '0; bus.ex_wdata_i = '0;
    bus.lsu_valid_i = 0; bus.lsu_waddr_i = '0; bus.lsu_wdata_i = '0;
    bus.fwd_raddr_i = '0;
    rst = 1;
    cyc(); cyc();
    rst = 0;
    chk("rst_we_a", bus.we_a_o, 0);
    chk("rst_we_b", bus.we_b_o, 0);
    chk("rst_count", bus.count_o, 0);
    chk("rst_ready", bus.lsu_ready_o, 1);
    chk("rst_waddr_a", bus.waddr_a_o, 0);

    // EX write one cycle latency
    ex(6'd5, 32'hDEADBEEF);
    cyc();
    idle();
    chk("ex_we_a", bus.we_a_o, 1);
    chk("ex_waddr_a", bus.waddr_a_o, 5);
    chk("ex_wdata_a", bus.wdata_a_o, 32'hDEADBEEF);
    chk("ex_we_b", bus.we_b_o, 0);
    cyc();
    chk("ex_we_a_drop", bus.we_a_o, 0);
    chk("ex_waddr_a_hold", bus.waddr_a_o, 5);

    // Four back-to-back loads
    first_k = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= 4) ld(AW'(k), 32'h100 + k);
      else idle();
      cyc();
      if (bus.we_b_o) begin
        if (first_k == 0) first_k = k;
        got.push_back(bus.waddr_b_o);
      end
    end
    chk("ld_first_cycle", first_k, 2);
    chk("ld_pulses", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++) chk("ld_order", got[i], i + 1);

    // lsu_valid held for six cycles
    for (int k = 0; k < 6; k++) begin
      ld(AW'(10 + k), 32'h200 + k);
      cyc();
      chk("hold_ready", bus.lsu_ready_o, 1);
    end
    idle();
    cyc(); cyc(); cyc();
    chk("drain_count", bus.count_o, 0);

    // Collision between popped load and EX write to addr 7
    ld(6'd7, 32'h77777777);
    cyc();
    chk("col_count1", bus.count_o, 1);
    idle();
    ex(6'd7, 32'hE7E7E7E7);
    cyc();
    idle();
    chk("col_we_a", bus.we_a_o, 1);
    chk("col_wdata_a", bus.wdata_a_o, 32'hE7E7E7E7);
    chk("col_we_b", bus.we_b_o, 0);
    chk("col_count0", bus.count_o, 0);

    // Address 0 on both paths
    ld(6'd0, 32'h1234);
    cyc();
    idle();
    chk("z_count1", bus.count_o, 1);
    ex(6'd0, 32'h55);
    cyc();
    idle();
    chk("z_we_a", bus.we_a_o, 0);
    chk("z_we_b", bus.we_b_o, 0);
    chk("z_count0", bus.count_o, 0);
    cyc();
    chk("z_we_b2", bus.we_b_o, 0);

    // Reset with a queued entry; inputs during reset ignored
    ld(6'd9, 32'hA5A5A5A5);
    bus.fwd_raddr_i = 6'd9;
    cyc();
    chk("r_count1", bus.count_o, 1);
`ifdef RF_WB_FWD_EN
    chk("r_fwd_hit", bus.fwd_hit_o, 1);
    chk("r_fwd_data", bus.fwd_data_o, 32'hA5A5A5A5);
`endif
    ld(6'd3, 32'h33);
    ex(6'd6, 32'h66);
    rst = 1;
    cyc();
    rst = 0;
    idle();
    chk("r_count0", bus.count_o, 0);
    chk("r_we_a", bus.we_a_o, 0);
    chk("r_we_b", bus.we_b_o, 0);
    chk("r_ready", bus.lsu_ready_o, 1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("r_no_we_b", bus.we_b_o, 0);
      chk("r_count_stay", bus.count_o, 0);
      chk("r_fwd_miss", bus.fwd_hit_o, 0);
    end

    // Randomised traffic with occasional reset
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.ex_valid_i  = $urandom_range(0, 1);
      bus.ex_waddr_i  = AW'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 6'h20 : 6'h00);
      bus.ex_wdata_i  = $urandom;
      bus.lsu_valid_i = ($urandom_range(0, 2) != 0);
      bus.lsu_waddr_i = AW'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 6'h20 : 6'h00);
      bus.lsu_wdata_i = $urandom;
      bus.fwd_raddr_i = AW'($urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 6'h20 : 6'h00);
      cyc();
    end
    rst = 0;
    idle();
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
